bounce_seq_checker: RTL

- Receive-side checker for the bouncing step counter stream: it samples a WIDTH-bit count on every in_valid cycle.
- Locks onto the sequence LO, LO+STEP, … HI, HI-STEP, … LO, LO+STEP, … and predicts each next value.
- Flags mismatches, reports current direction and counts direction reversals.
- Sits downstream of the counter (or after any link carrying it) as an in-system integrity monitor.

---
 rtl/bounce_seq_checker.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bounce_seq_checker.sv
// Bounce-sequence integrity checker: locks onto LO..HI..LO stepping stream.
// Optional sticky error flag via BOUNCE_CHK_STICKY_ERR_EN.
module bounce_seq_checker #(
    parameter int WIDTH = 8,
    parameter int STEP  = 7,
    parameter int LO    = 7,
    parameter int HI    = 210
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_count,
    output logic             locked,
    output logic             dir_up,
    output logic [WIDTH-1:0] expected,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic [15:0]      rev_cnt
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCK_UP, LOCK_DN} state_t;

    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] LO_W   = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_W   = WIDTH'(HI);

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] last;
    logic [WIDTH:0]   pred;
    logic [WIDTH:0]   samp;
    logic [WIDTH:0]   up_ref;
    logic [WIDTH:0]   dn_ref;
    logic [WIDTH:0]   up_s;
    logic [WIDTH:0]   dn_s;
    logic [WIDTH:0]   pred_up;
    logic [WIDTH:0]   pred_dn;
    logic             bad;
    logic             turn;

    // One extra bit keeps wrapped sums/differences from ever matching a sample.
    assign samp    = {1'b0, in_count};
    assign up_ref  = {1'b0, last} + STEP_W;
    assign dn_ref  = {1'b0, last} - STEP_W;
    assign up_s    = samp + STEP_W;
    assign dn_s    = samp - STEP_W;
    assign pred_up = (in_count < HI_W) ? up_s : dn_s;
    assign pred_dn = (in_count > LO_W) ? dn_s : up_s;

    assign expected = pred[WIDTH-1:0];

    always_comb begin
        nxt  = state;
        bad  = 1'b0;
        turn = 1'b0;
        case (state)
            IDLE: nxt = ACQ;
            ACQ: begin
                if (samp == up_ref && last < HI_W)
                    nxt = LOCK_UP;
                else if (samp == dn_ref && last > LO_W)
                    nxt = LOCK_DN;
                else
                    bad = 1'b1;
            end
            LOCK_UP: begin
                if (samp == pred) begin
                    if (last >= HI_W) begin
                        turn = 1'b1;
                        nxt  = LOCK_DN;
                    end
                end else begin
                    bad = 1'b1;
                    nxt = ACQ;
                end
            end
            LOCK_DN: begin
                if (samp == pred) begin
                    if (last <= LO_W) begin
                        turn = 1'b1;
                        nxt  = LOCK_UP;
                    end
                end else begin
                    bad = 1'b1;
                    nxt = ACQ;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            last    <= '0;
            pred    <= '0;
            locked  <= 1'b0;
            dir_up  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
            rev_cnt <= '0;
        end else if (in_valid) begin
            state  <= nxt;
            last   <= in_count;
            locked <= (nxt == LOCK_UP) || (nxt == LOCK_DN);
            if (nxt == LOCK_UP) begin
                pred   <= pred_up;
                dir_up <= 1'b1;
            end else if (nxt == LOCK_DN) begin
                pred   <= pred_dn;
                dir_up <= 1'b0;
            end
            if (turn)
                rev_cnt <= rev_cnt + 16'd1;
            if (bad && err_cnt != 8'hff)
                err_cnt <= err_cnt + 8'd1;
`ifdef BOUNCE_CHK_STICKY_ERR_EN
            err <= err | bad;
`else
            err <= bad;
`endif
        end else begin
`ifdef BOUNCE_CHK_STICKY_ERR_EN
            err <= err;
`else
            err <= 1'b0;
`endif
        end
    end

endmodule
